// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: widths, FSM encodings and the pending-access record.
// Latency and backpressure are not applicable: this package holds only types and constants.
package mem_stage_pkg;

    localparam int WORD_W    = 16;
    localparam int REG_IDX_W = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Context of the access in flight, needed again when it retires.
    typedef struct packed {
        logic                 is_load;
        logic                 reg_wr;
        logic [REG_IDX_W-1:0] wr_reg;
    } pend_op_t;

    function automatic logic is_unaligned(input logic [WORD_W-1:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of execution-stage inputs, data-memory port and write-back outputs around mem_stage.
// Latency and backpressure are not applicable: the bundle is wiring only; stalls are signalled on stall_pipe.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                 ex_valid;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic [WORD_W-1:0]    ex_alu_out;
    logic [WORD_W-1:0]    ex_set;
    logic                 ex_set_sel;
    logic [WORD_W-1:0]    ex_wdata;
    logic                 ex_reg_wr;
    logic [REG_IDX_W-1:0] ex_wr_reg;

    logic                 mem_req;
    logic                 mem_wr;
    logic [WORD_W-1:0]    mem_addr;
    logic [WORD_W-1:0]    mem_wdata;
    logic [WORD_W-1:0]    mem_rdata;
    logic                 mem_done;

    logic                 stall_pipe;

    logic                 wb_valid;
    logic [WORD_W-1:0]    wb_data;
    logic                 wb_reg_wr;
    logic [REG_IDX_W-1:0] wb_wr_reg;
    logic                 wb_err;

    // Pipeline and data memory on one side, the memory stage on the other.
    modport master (
        output ex_valid, ex_mem_read, ex_mem_write, ex_alu_out, ex_set, ex_set_sel,
               ex_wdata, ex_reg_wr, ex_wr_reg, mem_rdata, mem_done,
        input  mem_req, mem_wr, mem_addr, mem_wdata, stall_pipe,
               wb_valid, wb_data, wb_reg_wr, wb_wr_reg, wb_err
    );

    modport slave (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_alu_out, ex_set, ex_set_sel,
               ex_wdata, ex_reg_wr, ex_wr_reg, mem_rdata, mem_done,
        output mem_req, mem_wr, mem_addr, mem_wdata, stall_pipe,
               wb_valid, wb_data, wb_reg_wr, wb_wr_reg, wb_err
    );

endinterface

// File: rtl/mem_stage_wait_counter.sv
// Wait-cycle counter for an outstanding memory access; term flags the last permitted cycle (TIMEOUT-1).
// Count updates one cycle after clear/enable; no backpressure, clear has priority over enable.
module mem_wait_counter #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory stage: retires ALU ops in 1 cycle, runs loads/stores on a handshaked data port, flags bad/timed-out accesses.
// Stalls upstream (stall_pipe) for the whole WAIT phase; one bubble follows every memory op.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    logic [0:0]       state;
    pend_op_t         pend;
    logic             is_mem;
    logic             bad_access;
    logic             start_access;
    logic             cnt_en;
    logic             cnt_term;
    logic [CNT_W-1:0] wait_cnt;

    always_comb begin
        is_mem       = bus.ex_mem_read | bus.ex_mem_write;
        bad_access   = (bus.ex_mem_read & bus.ex_mem_write)
                     | (is_mem & is_unaligned(bus.ex_alu_out));
        start_access = (state == ST_IDLE) & bus.ex_valid & is_mem & ~bad_access;
        cnt_en       = (state == ST_WAIT) & ~bus.mem_done & ~cnt_term;
    end

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_access),
        .enable (cnt_en),
        .count  (wait_cnt),
        .term   (cnt_term)
    );

    assign bus.stall_pipe = (state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pend          <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_data   <= '0;
            bus.wb_reg_wr <= 1'b0;
            bus.wb_wr_reg <= '0;
            bus.wb_err    <= 1'b0;
        end else begin
            bus.mem_req  <= 1'b0;
            bus.wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        if (start_access) begin
                            bus.mem_req    <= 1'b1;
                            bus.mem_wr     <= bus.ex_mem_write;
                            bus.mem_addr   <= bus.ex_alu_out;
                            bus.mem_wdata  <= bus.ex_wdata;
                            pend.is_load   <= bus.ex_mem_read;
                            pend.reg_wr    <= bus.ex_reg_wr;
                            pend.wr_reg    <= bus.ex_wr_reg;
                            state          <= ST_WAIT;
                        end else begin
                            // Non-memory ops and rejected accesses both retire immediately.
                            bus.wb_valid  <= 1'b1;
                            bus.wb_data   <= bus.ex_set_sel ? bus.ex_set : bus.ex_alu_out;
                            bus.wb_reg_wr <= bus.ex_reg_wr & ~bad_access;
                            bus.wb_wr_reg <= bus.ex_wr_reg;
                            bus.wb_err    <= bad_access;
                        end
                    end
                end
                ST_WAIT: begin
                    // Completion is checked before the timeout so a done on the last cycle still succeeds.
                    if (bus.mem_done) begin
                        bus.wb_valid  <= 1'b1;
                        bus.wb_err    <= 1'b0;
                        bus.wb_wr_reg <= pend.wr_reg;
                        if (pend.is_load) begin
                            bus.wb_data   <= bus.mem_rdata;
                            bus.wb_reg_wr <= pend.reg_wr;
                        end else begin
                            bus.wb_data   <= bus.mem_addr;
                            bus.wb_reg_wr <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end else if (cnt_term) begin
                        bus.wb_valid  <= 1'b1;
                        bus.wb_err    <= 1'b1;
                        bus.wb_reg_wr <= 1'b0;
                        bus.wb_wr_reg <= pend.wr_reg;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_wait_bounded: assert property (@(posedge clk) disable iff (rst)
        (state == ST_WAIT) |-> (int'(wait_cnt) < TIMEOUT));

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: retirements are queued as expected when driven and compared once observed.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic [WORD_W-1:0]    data;
        logic                 reg_wr;
        logic [REG_IDX_W-1:0] wr_reg;
        logic                 err;
        logic                 chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    logic [WORD_W-1:0]    obs_data   [0:63];
    logic                 obs_reg_wr [0:63];
    logic [REG_IDX_W-1:0] obs_wr_reg [0:63];
    logic                 obs_err    [0:63];
    int                   obs_stamp  [0:63];
    int obs_wr    = 0;
    int obs_rd    = 0;
    int req_cnt   = 0;
    int stall_cnt = 0;
    int held_bad  = 0;
    int neg_cnt   = 0;
    logic              req_wr    = 1'b0;
    logic [WORD_W-1:0] req_addr  = '0;
    logic [WORD_W-1:0] req_wdata = '0;

    // Passive monitor: records requests, stall cycles, held-bus violations and retirements.
    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        if (bus.mem_req === 1'b1) begin
            req_cnt   <= req_cnt + 1;
            req_wr    <= bus.mem_wr;
            req_addr  <= bus.mem_addr;
            req_wdata <= bus.mem_wdata;
        end
        if (bus.stall_pipe === 1'b1) begin
            stall_cnt <= stall_cnt + 1;
            if (bus.mem_req !== 1'b1 && (bus.mem_wr !== req_wr || bus.mem_addr !== req_addr
                                         || bus.mem_wdata !== req_wdata))
                held_bad <= held_bad + 1;
        end
        if (bus.wb_valid === 1'b1) begin
            obs_data[obs_wr % 64]   <= bus.wb_data;
            obs_reg_wr[obs_wr % 64] <= bus.wb_reg_wr;
            obs_wr_reg[obs_wr % 64] <= bus.wb_wr_reg;
            obs_err[obs_wr % 64]    <= bus.wb_err;
            obs_stamp[obs_wr % 64]  <= neg_cnt;
            obs_wr                  <= obs_wr + 1;
        end
    end

    task automatic idle_ex();
        bus.ex_valid     = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_mem_write = 1'b0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [WORD_W-1:0] alu,
                            input logic [WORD_W-1:0] set, input logic sel,
                            input logic [WORD_W-1:0] wd, input logic rw,
                            input logic [REG_IDX_W-1:0] wreg);
        bus.ex_valid     = 1'b1;
        bus.ex_mem_read  = rd;
        bus.ex_mem_write = wr;
        bus.ex_alu_out   = alu;
        bus.ex_set       = set;
        bus.ex_set_sel   = sel;
        bus.ex_wdata     = wd;
        bus.ex_reg_wr    = rw;
        bus.ex_wr_reg    = wreg;
    endtask

    task automatic push_exp(input logic [WORD_W-1:0] d, input logic rw,
                            input logic [REG_IDX_W-1:0] wreg, input logic e, input logic cd);
        exp_t x;
        x.data = d; x.reg_wr = rw; x.wr_reg = wreg; x.err = e; x.chk_data = cd;
        exp_q.push_back(x);
    endtask

    // Raises mem_done so that stall_pipe is seen high for exactly 'stall' cycles after capture.
    task automatic complete_after(input int stall, input logic [WORD_W-1:0] rdata);
        repeat (stall - 1) begin @(posedge clk); #1; end
        bus.mem_done  = 1'b1;
        bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic sb_drain(input string tag);
        exp_t e;
        int   i;
        n_checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s retire_count: got %0d retirements, expected %0d",
                     tag, obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front();
            i = obs_rd % 64;
            n_checks++;
            if ((e.chk_data && obs_data[i] !== e.data) || obs_reg_wr[i] !== e.reg_wr
                || obs_wr_reg[i] !== e.wr_reg || obs_err[i] !== e.err) begin
                n_fail++;
                $display("FAIL %s retire: got data=%h reg_wr=%b wr_reg=%0d err=%b, expected data=%h(chk=%b) reg_wr=%b wr_reg=%0d err=%b",
                         tag, obs_data[i], obs_reg_wr[i], obs_wr_reg[i], obs_err[i],
                         e.data, e.chk_data, e.reg_wr, e.wr_reg, e.err);
            end
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_ex();
        bus.mem_done = 1'b0; bus.mem_rdata = '0;
        bus.ex_alu_out = '0; bus.ex_set = '0; bus.ex_set_sel = 1'b0;
        bus.ex_wdata = '0; bus.ex_reg_wr = 1'b0; bus.ex_wr_reg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.mem_req, bus.mem_wr, bus.wb_valid, bus.wb_reg_wr, bus.wb_err, bus.stall_pipe} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got req=%b wr=%b wb_valid=%b reg_wr=%b err=%b stall=%b, expected all 0",
                     bus.mem_req, bus.mem_wr, bus.wb_valid, bus.wb_reg_wr, bus.wb_err, bus.stall_pipe);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_wr_reg} !== 51'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr=%h wdata=%h wb_data=%h wr_reg=%0d, expected all 0",
                     bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_wr_reg);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        int r0, s0;
        r0 = req_cnt; s0 = stall_cnt;
        drive_op(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0, 1'b1, 3'd3);
        push_exp(16'h1234, 1'b1, 3'd3, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL alu_latency: wb_valid=%b one cycle after capture, expected 1", bus.wb_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (stall_cnt != s0 || req_cnt != r0) begin
            n_fail++; $display("FAIL alu_no_stall: stall cycles=%0d requests=%0d, expected 0 and 0",
                               stall_cnt - s0, req_cnt - r0);
        end
        sb_drain("alu");
    endtask

    task automatic test_set_sel();
        drive_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0, 1'b1, 3'd2);
        push_exp(16'h0001, 1'b1, 3'd2, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 16'h00C3, 16'h0001, 1'b0, 16'h0, 1'b0, 3'd6);
        push_exp(16'h00C3, 1'b0, 3'd6, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        @(posedge clk); #1;
        sb_drain("set_sel");
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = obs_wr;
        for (int k = 0; k < 3; k++) begin
            drive_op(1'b0, 1'b0, 16'h1000 + 16'(k), 16'h0, 1'b0, 16'h0, 1'b1, 3'(k + 1));
            push_exp(16'h1000 + 16'(k), 1'b1, 3'(k + 1), 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        idle_ex();
        @(posedge clk); #1;
        n_checks++;
        if (obs_wr - w0 != 3 || obs_stamp[(w0 + 2) % 64] - obs_stamp[w0 % 64] != 2) begin
            n_fail++; $display("FAIL b2b_throughput: %0d retirements spanning %0d cycles, expected 3 spanning 2",
                               obs_wr - w0, obs_stamp[(w0 + 2) % 64] - obs_stamp[w0 % 64]);
        end
        sb_drain("b2b");
    endtask

    task automatic test_load();
        int r0, s0;
        r0 = req_cnt; s0 = stall_cnt;
        drive_op(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 1'b1, 3'd5);
        push_exp(16'hBEEF, 1'b1, 3'd5, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        complete_after(3, 16'hBEEF);
        @(negedge clk);
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL load_retire: wb_valid=%b after mem_done, expected 1", bus.wb_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (req_cnt - r0 != 1 || req_wr !== 1'b0 || req_addr !== 16'h0040) begin
            n_fail++; $display("FAIL load_req: pulses=%0d wr=%b addr=%h, expected 1 0 0040",
                               req_cnt - r0, req_wr, req_addr);
        end
        n_checks++;
        if (stall_cnt - s0 != 3) begin
            n_fail++; $display("FAIL load_stall: stall cycles=%0d, expected 3", stall_cnt - s0);
        end
        sb_drain("load");
    endtask

    task automatic test_load_min();
        int s0;
        s0 = stall_cnt;
        drive_op(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b1, 3'd7);
        push_exp(16'h1357, 1'b1, 3'd7, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        complete_after(1, 16'h1357);
        @(negedge clk);
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL load_min_latency: wb_valid=%b, expected 1", bus.wb_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (stall_cnt - s0 != 1) begin
            n_fail++; $display("FAIL load_min_stall: stall cycles=%0d, expected 1", stall_cnt - s0);
        end
        sb_drain("load_min");
    endtask

    task automatic test_store();
        int r0, h0;
        r0 = req_cnt; h0 = held_bad;
        drive_op(1'b0, 1'b1, 16'h0102, 16'h0, 1'b0, 16'hA5A5, 1'b1, 3'd4);
        push_exp(16'h0102, 1'b0, 3'd4, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        bus.ex_wdata = 16'h0000; bus.ex_alu_out = 16'hFFFE;
        complete_after(3, 16'h7777);
        @(posedge clk); #1;
        n_checks++;
        if (req_cnt - r0 != 1 || req_wr !== 1'b1 || req_wdata !== 16'hA5A5 || req_addr !== 16'h0102) begin
            n_fail++; $display("FAIL store_req: pulses=%0d wr=%b addr=%h wdata=%h, expected 1 1 0102 A5A5",
                               req_cnt - r0, req_wr, req_addr, req_wdata);
        end
        n_checks++;
        if (held_bad != h0) begin
            n_fail++; $display("FAIL store_held: %0d wait cycles with changed bus, expected 0", held_bad - h0);
        end
        sb_drain("store");
    endtask

    task automatic test_errors();
        int r0, s0;
        r0 = req_cnt; s0 = stall_cnt;
        drive_op(1'b1, 1'b0, 16'h0033, 16'h0, 1'b0, 16'h0, 1'b1, 3'd6);
        push_exp(16'h0, 1'b0, 3'd6, 1'b1, 1'b0);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_err !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL unaligned: wb_valid=%b err=%b req=%b, expected 1 1 0",
                               bus.wb_valid, bus.wb_err, bus.mem_req);
        end
        @(posedge clk); #1;
        drive_op(1'b1, 1'b1, 16'h0020, 16'h0, 1'b0, 16'h0, 1'b1, 3'd7);
        push_exp(16'h0, 1'b0, 3'd7, 1'b1, 1'b0);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_err !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL read_write: wb_valid=%b err=%b req=%b, expected 1 1 0",
                               bus.wb_valid, bus.wb_err, bus.mem_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if (req_cnt != r0 || stall_cnt != s0) begin
            n_fail++; $display("FAIL err_no_access: requests=%0d stall cycles=%0d, expected 0 0",
                               req_cnt - r0, stall_cnt - s0);
        end
        sb_drain("errors");
    endtask

    task automatic test_timeout();
        int s0, n, w1, s1;
        s0 = stall_cnt;
        drive_op(1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 16'h0, 1'b1, 3'd1);
        push_exp(16'h0, 1'b0, 3'd1, 1'b1, 1'b0);
        @(posedge clk); #1; idle_ex();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wb_valid !== 1'b1 && n < 12);
        n_checks++;
        if (n - 1 != TO) begin
            n_fail++; $display("FAIL timeout_latency: error retired %0d cycles into WAIT, expected %0d", n - 1, TO);
        end
        @(posedge clk); #1;
        n_checks++;
        if (stall_cnt - s0 != TO) begin
            n_fail++; $display("FAIL timeout_stall: stall cycles=%0d, expected %0d", stall_cnt - s0, TO);
        end
        w1 = obs_wr; s1 = stall_cnt;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (obs_wr != w1 || stall_cnt != s1) begin
            n_fail++; $display("FAIL late_done: retirements=%0d stall cycles=%0d after late done, expected 0 0",
                               obs_wr - w1, stall_cnt - s1);
        end
        drive_op(1'b0, 1'b0, 16'h5A5A, 16'h0, 1'b0, 16'h0, 1'b1, 3'd2);
        push_exp(16'h5A5A, 1'b1, 3'd2, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        @(posedge clk); #1;
        sb_drain("timeout");
    endtask

    task automatic test_reset_mid_wait();
        int w0;
        w0 = obs_wr;
        drive_op(1'b1, 1'b0, 16'h0090, 16'h0, 1'b0, 16'h0, 1'b1, 3'd3);
        @(posedge clk); #1; idle_ex();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.stall_pipe !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_wait: stall_pipe=%b after reset, expected 0", bus.stall_pipe);
        end
        @(posedge clk); #1;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h4321;
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (obs_wr != w0) begin
            n_fail++; $display("FAIL reset_abandon: %0d retirements after reset, expected 0", obs_wr - w0);
        end
        sb_drain("reset_mid_wait");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_set_sel();
        test_back_to_back();
        test_load();
        test_load_min();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of the execution stage.
- Consumes the ALU result (used as data address or write-back value), the condition-set result and the store data produced by execution.
- Drives a multi-cycle, handshaked data-memory port and stalls the pipeline while an access is outstanding.
- Registers the write-back bundle for the MEM/WB boundary, and flags unaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 32, max cycles spent in WAIT before the access is abandoned with an error (legal range 2..255).
- CNT_W, 8, width of the wait counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  execution stage presents an instruction this cycle
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_alu_out  in  16  ALU result; data address for load/store
- ex_set  in  16  condition-set result
- ex_set_sel  in  1  1 = write back ex_set instead of ex_alu_out
- ex_wdata  in  16  store data (second register operand)
- ex_reg_wr  in  1  instruction writes the register file
- ex_wr_reg  in  3  destination register
- mem_req  out  1  one-cycle request pulse to data memory
- mem_wr  out  1  request is a write (valid with mem_req)
- mem_addr  out  16  request address, held stable until done or abandon
- mem_wdata  out  16  store data, held stable with mem_addr
- mem_rdata  in  16  load data, valid with mem_done
- mem_done  in  1  access complete
- stall_pipe  out  1  upstream must hold its inputs; asserted whenever state != IDLE
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  16  write-back value
- wb_reg_wr  out  1  register-file write enable (forced 0 on error)
- wb_wr_reg  out  3  destination register
- wb_err  out  1  unaligned, illegal or timed-out access; valid with wb_valid

Behaviour:
- Reset (rst=1 at edge): state=IDLE; mem_req, mem_wr, wb_valid, wb_reg_wr and wb_err = 0; mem_addr, mem_wdata, wb_data = 0; wb_wr_reg = 0; counter = 0. Reset mid-WAIT abandons the access, and a later mem_done is ignored.
- States: IDLE, WAIT. All outputs are registered except stall_pipe = (state==WAIT).
- Default each edge: wb_valid<=0 and mem_req<=0 (both are pulses).
- IDLE, ex_valid=0: no action.
- IDLE, ex_valid=1, non-memory instruction: next edge wb_valid=1; wb_data = ex_set_sel ? ex_set : ex_alu_out; wb_reg_wr = ex_reg_wr; wb_err=0. Latency is 1 cycle, throughput is 1 per cycle.
- IDLE, ex_mem_read & ex_mem_write both 1: retire immediately with wb_err=1, wb_reg_wr=0, no memory request.
- IDLE, load/store with ex_alu_out[0]=1 (unaligned): retire immediately with wb_err=1, wb_reg_wr=0, no memory request.
- IDLE, aligned load/store: mem_req<=1; mem_wr<=ex_mem_write; mem_addr<=ex_alu_out; mem_wdata<=ex_wdata. Latch ex_reg_wr, ex_wr_reg and the load flag. counter<=0; state<=WAIT.
- WAIT:
  - mem_done=1: wb_valid<=1 and state<=IDLE. Load: wb_data<=mem_rdata, wb_reg_wr<=latched reg_wr. Store: wb_data<=mem_addr, wb_reg_wr<=0.
  - mem_done=0 and counter==TIMEOUT-1: wb_valid<=1, wb_err<=1, wb_reg_wr<=0, state<=IDLE.
  - Otherwise: counter<=counter+1.
  - mem_done and timeout in the same cycle: done wins.
  - mem_done in the first WAIT cycle is legal, giving minimum load latency = 2 cycles after capture.
- stall_pipe stays high through the cycle mem_done is seen. The next instruction is captured in the first IDLE cycle, so there is one bubble after each memory op.
- mem_done while IDLE: ignored.
- mem_addr and mem_wdata hold their last values in IDLE.

Decomposition:
- Shared package (pipeline defs): state encodings ST_IDLE and ST_WAIT; WORD_W=16; REG_IDX_W=3.
- One sub-module, mem_wait_counter: clear, enable, CNT_W-bit count, terminal flag at TIMEOUT-1, synchronous reset.

Test Plan:
- Reset then ALU op: ex_alu_out=0x1234, ex_reg_wr=1, ex_wr_reg=3 -> next cycle wb_valid=1, wb_data=0x1234, wb_wr_reg=3, stall_pipe never asserted.
- Set-select op: ex_set=0x0001, ex_alu_out=0xFFFF, ex_set_sel=1 -> wb_data=0x0001.
- Aligned load to 0x0040 with mem_done 3 cycles after mem_req, mem_rdata=0xBEEF:
  - mem_req is a single pulse with mem_wr=0 and mem_addr=0x0040.
  - stall_pipe is high for 3 cycles.
  - wb_data=0xBEEF, wb_reg_wr=1.
- Store of 0xA5A5 to 0x0102: mem_wr=1 and mem_wdata=0xA5A5 held until done; retirement has wb_reg_wr=0 and wb_err=0.
- Unaligned load to 0x0033, then read+write both set: each retires next cycle with wb_err=1, mem_req=0, wb_reg_wr=0.
- TIMEOUT=4 with mem_done never asserted: wb_err pulse exactly 4 cycles after entering WAIT. A late mem_done is ignored, and a following ALU op retires normally.
